ras: RTL

RAS -- requirements
Module: ras

---
 rtl/core_types_pkg.sv | 17 +
 rtl/ras_if.sv | 29 ++
 rtl/ras.sv | 75 +++++++
 3 files changed

// File: rtl/core_types_pkg.sv
// Core-wide types and sizing shared by the predictor blocks.
// Return-address-stack geometry lives here so checkpoint logic agrees.
package core_types_pkg;

    localparam int XLEN          = 32;
    localparam int RAS_DEPTH     = 8;
    localparam int LOG_RAS_DEPTH = $clog2(RAS_DEPTH);

    typedef logic [LOG_RAS_DEPTH-1:0] ras_index_t;
    typedef logic [LOG_RAS_DEPTH:0]   ras_count_t;
    typedef logic [XLEN-1:0]          word_t;

    function automatic ras_count_t ras_sat(input ras_count_t c);
        return (c > ras_count_t'(RAS_DEPTH)) ? ras_count_t'(RAS_DEPTH) : c;
    endfunction

endpackage

// File: rtl/ras_if.sv
// Signal bundle between the fetch predictor and the return address stack.
// The predictor is the master; the stack is the slave.
interface ras_if;
    import core_types_pkg::*;

    logic       push_valid;
    word_t      push_addr;
    logic       pop_valid;
    logic       restore_valid;
    ras_index_t restore_index;
    ras_count_t restore_count;
    logic       ret_valid;
    word_t      ret_target;
    ras_index_t ras_index;
    ras_count_t ras_count;

    modport master (
        output push_valid, push_addr, pop_valid,
        output restore_valid, restore_index, restore_count,
        input  ret_valid, ret_target, ras_index, ras_count
    );

    modport slave (
        input  push_valid, push_addr, pop_valid,
        input  restore_valid, restore_index, restore_count,
        output ret_valid, ret_target, ras_index, ras_count
    );

endinterface

// File: rtl/ras.sv
// Return address stack: circular flop array with top pointer and
// occupancy; overflow overwrites the oldest entry, underflow is ignored.
module ras
    import core_types_pkg::*;
#(
    parameter int RAS_DEPTH = core_types_pkg::RAS_DEPTH,
    parameter int XLEN      = core_types_pkg::XLEN
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             push_valid,
    input  logic [XLEN-1:0]  push_addr,
    input  logic             pop_valid,
    input  logic             restore_valid,
    input  ras_index_t       restore_index,
    input  ras_count_t       restore_count,
    output logic             ret_valid,
    output logic [XLEN-1:0]  ret_target,
    output ras_index_t       ras_index,
    output ras_count_t       ras_count
);

    localparam ras_count_t FULL = ras_count_t'(RAS_DEPTH);

    logic [XLEN-1:0] mem_q [RAS_DEPTH];
    ras_index_t      ptr_q, ptr_d;
    ras_count_t      cnt_q, cnt_d;
    logic            we;
    ras_index_t      wa;

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        we    = 1'b0;
        wa    = ptr_q;
        if (restore_valid) begin
            ptr_d = restore_index;
            cnt_d = ras_sat(restore_count);
        end else if (push_valid && pop_valid) begin
            // Return then call: the new address replaces the top in place.
            we    = 1'b1;
            cnt_d = (cnt_q == '0) ? ras_count_t'(1) : cnt_q;
        end else if (push_valid) begin
            we    = 1'b1;
            wa    = ptr_q + ras_index_t'(1);
            ptr_d = wa;
            cnt_d = (cnt_q == FULL) ? FULL : cnt_q + ras_count_t'(1);
        end else if (pop_valid && cnt_q != '0) begin
            ptr_d = ptr_q - ras_index_t'(1);
            cnt_d = cnt_q - ras_count_t'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ptr_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            if (we) begin
                mem_q[wa] <= push_addr;
            end
        end
    end

    assign ret_valid  = (cnt_q != '0);
    assign ret_target = mem_q[ptr_q];
    assign ras_index  = ptr_q;
    assign ras_count  = cnt_q;

endmodule
